// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter: ALU writeback vs. long-latency results, with a
// one-entry hold buffer, starvation guard and decode-stage scoreboard.
module regfile_wb_scheduler #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int MAX_LONG   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    issue_valid,
  input  logic                    issue_long,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  input  logic [$clog2(NREG)-1:0] issue_rs1,
  input  logic [$clog2(NREG)-1:0] issue_rs2,
  input  logic                    issue_use_rs1,
  input  logic                    issue_use_rs2,
  output logic                    issue_stall,
  input  logic                    alu_wb_valid,
  input  logic [$clog2(NREG)-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]         alu_wb_data,
  output logic                    wb_stall,
  input  logic                    long_valid,
  input  logic [$clog2(NREG)-1:0] long_rd,
  input  logic [XLEN-1:0]         long_data,
  output logic                    long_ready,
  output logic                    RegWrite,
  output logic [$clog2(NREG)-1:0] Wreg,
  output logic [XLEN-1:0]         Wdata,
  output logic [NREG-1:0]         pending
);
  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(MAX_LONG + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic          en;
    logic [RW-1:0] rd;
    logic [XLEN-1:0] data;
    logic          from_long;
  } wr_req_t;

  logic            hold_full;
  logic [RW-1:0]   hold_rd;
  logic [XLEN-1:0] hold_data;
  logic [SW-1:0]   starve_cnt;
  logic [CW-1:0]   out_cnt;
  logic            wb_long;
  logic [NREG-1:0] pend_q, pend_nxt;

  logic    starve_hit, alu_go, hold_go, long_acc, long_zero, long_direct, long_cap;
  logic    hazard, sb_full, set_en, clr_en;
  wr_req_t wr_nxt;
  logic [1:0]    cnt_dec;
  logic [CW:0]   cnt_sum, cnt_nxt;

  // Write-port arbitration: a starved hold entry beats the ALU, otherwise ALU first.
  always_comb begin
    starve_hit  = hold_full && (starve_cnt == SW'(STARVE_MAX));
    alu_go      = !starve_hit && alu_wb_valid && !wb_stall;
    hold_go     = hold_full && !alu_go;
    long_ready  = !hold_full;
    long_acc    = long_valid && !hold_full;
    long_zero   = (long_rd == '0);
    long_direct = long_acc && !alu_go && !long_zero;
    long_cap    = long_acc && alu_go && !long_zero;
  end

  always_comb begin
    wr_nxt = '0;
    if (hold_go) begin
      wr_nxt = '{en: 1'b1, rd: hold_rd, data: hold_data, from_long: 1'b1};
    end else if (alu_go) begin
      if (alu_wb_rd != '0)
        wr_nxt = '{en: 1'b1, rd: alu_wb_rd, data: alu_wb_data, from_long: 1'b0};
    end else if (long_direct) begin
      wr_nxt = '{en: 1'b1, rd: long_rd, data: long_data, from_long: 1'b1};
    end
  end

  always_comb begin
    hazard = (issue_use_rs1 && pend_q[issue_rs1]) ||
             (issue_use_rs2 && pend_q[issue_rs2]) ||
             ((issue_rd != '0) && pend_q[issue_rd]);
    sb_full     = issue_long && (out_cnt == CW'(MAX_LONG));
    issue_stall = issue_valid && (hazard || sb_full);
    set_en      = issue_valid && !issue_stall && issue_long && (issue_rd != '0);
    clr_en      = RegWrite && wb_long;
  end

  // Set after clear so a same-register collision leaves the bit set.
  always_comb begin
    pend_nxt = pend_q;
    if (clr_en) pend_nxt[Wreg] = 1'b0;
    if (set_en) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Outstanding count: up to two decrements per cycle (long commit + dropped rd=0 result).
  always_comb begin
    cnt_dec = {1'b0, clr_en} + {1'b0, long_acc && long_zero};
    cnt_sum = {1'b0, out_cnt} + (CW+1)'(set_en);
    cnt_nxt = (cnt_sum >= (CW+1)'(cnt_dec)) ? (cnt_sum - (CW+1)'(cnt_dec)) : '0;
  end

  assign pending = pend_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RegWrite   <= 1'b0;
      Wreg       <= '0;
      Wdata      <= '0;
      wb_long    <= 1'b0;
      wb_stall   <= 1'b0;
      hold_full  <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
      starve_cnt <= '0;
      out_cnt    <= '0;
      pend_q     <= '0;
    end else begin
      RegWrite <= wr_nxt.en;
      Wreg     <= wr_nxt.rd;
      Wdata    <= wr_nxt.data;
      wb_long  <= wr_nxt.from_long;
      wb_stall <= starve_hit;
      if (hold_go) begin
        hold_full <= 1'b0;
      end else if (long_cap) begin
        hold_full <= 1'b1;
        hold_rd   <= long_rd;
        hold_data <= long_data;
      end
      if (hold_go || !hold_full)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      out_cnt <= cnt_nxt[CW-1:0];
      pend_q  <= pend_nxt;
    end
  end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single write port of the 32x32 integer register file between two sources:
  - the pipeline ALU writeback, single-cycle;
  - the long-latency result port from LSU/MUL/DIV, with valid/ready.
- Holds a pending-destination scoreboard and produces the decode-stage hazard stall.
- Drives the register file's RegWrite/Wreg/Wdata. Register x0 is never written.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers (register index is 5 bits).
- MAX_LONG, 4, maximum in-flight long-latency ops.
- STARVE_MAX, 8, cycles a held long result may wait before forcing an ALU writeback stall.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode issuing an instruction this cycle.
- issue_long  in  1  issued op returns its result via the long port.
- issue_rd  in  5  destination register.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_use_rs1  in  1  rs1 is read.
- issue_use_rs2  in  1  rs2 is read.
- issue_stall  out  1  combinational; issue must be held this cycle.
- alu_wb_valid  in  1  ALU result present.
- alu_wb_rd  in  5  ALU destination.
- alu_wb_data  in  XLEN  ALU result.
- wb_stall  out  1  registered; ALU writeback must hold its inputs.
- long_valid  in  1  long result present.
- long_rd  in  5  long destination.
- long_data  in  XLEN  long result.
- long_ready  out  1  combinational; long result accepted when long_valid && long_ready.
- RegWrite  out  1  registered register-file write enable.
- Wreg  out  5  registered write index.
- Wdata  out  XLEN  registered write data.
- pending  out  NREG  scoreboard state (debug/trace).

Behaviour:
- Reset (async, RST_N=0): RegWrite=0, Wreg=0, Wdata=0, pending=0, hold buffer empty, outstanding count=0, starve counter=0, wb_stall=0. A reset mid-operation discards the held result and all pending bits.
- Write port latency: the source chosen in cycle N appears on RegWrite/Wreg/Wdata in cycle N+1. The register file commits at the end of N+1.
- Write-port selection each cycle, in priority order:
  - a) hold full and starve counter == STARVE_MAX: write hold; wb_stall=1 next cycle.
  - b) alu_wb_valid && !wb_stall: write ALU.
  - c) hold full: write hold.
  - d) long_valid: write long directly.
  - e) otherwise RegWrite=0 next cycle.
- Hold buffer (1 entry):
  - long_ready = !hold_full.
  - A long result accepted in the same cycle the ALU wins is captured into the hold buffer.
  - While the hold buffer is full, long_ready=0.
- Starve counter: increments each cycle the hold buffer is full and not written, saturating at STARVE_MAX. It clears when the hold buffer drains.
- wb_stall lasts exactly one cycle. The ALU keeps alu_wb_valid/rd/data stable while wb_stall=1 and is written in the following cycle.
- rd == 0 on either source: the result is accepted and dropped. No RegWrite, not placed in the hold buffer.
- Scoreboard:
  - issue_stall = issue_valid && (hazard || full). hazard is any of:
    - issue_use_rs1 && pending[rs1];
    - issue_use_rs2 && pending[rs2];
    - issue_rd != 0 && pending[issue_rd] (WAW).
  - full = issue_long && outstanding == MAX_LONG.
  - pending[0] is constant 0.
  - Set: issue_valid && !issue_stall && issue_long && issue_rd != 0 sets pending[issue_rd] and increments outstanding.
  - Clear: pending[Wreg] clears and outstanding decrements at the end of the cycle in which RegWrite=1 from a long source.
  - A long result with rd=0 decrements outstanding at acceptance.
  - Simultaneous set and clear on the same register: set wins. Simultaneous increment and decrement: count unchanged.
- A long result for a register not marked pending is written normally. No error flag.

Test Plan:
- Reset release, idle -> RegWrite=0, long_ready=1, pending=0, issue_stall=0.
- ALU writeback alone: alu_wb_valid=1, rd=5, data=0xDEADBEEF in cycle N -> cycle N+1: RegWrite=1, Wreg=5, Wdata=0xDEADBEEF. With rd=0 -> RegWrite stays 0.
- Conflict: ALU (rd=3, 0x11) and long (rd=7, 0x22) valid in cycle N -> N+1 writes x3. N+2 writes x7 from hold. long_ready=0 during N+1. pending[7] clears after N+2.
- Starvation: hold full with 8 consecutive ALU writebacks -> after STARVE_MAX cycles the hold is written, wb_stall=1 for exactly one cycle, and the stalled ALU result is written the next cycle.
- Hazards:
  - Long issue to x9 accepted, then an instruction reading rs1=x9 -> issue_stall=1 until the cycle after the long write of x9 commits.
  - Fifth long issue with MAX_LONG=4 outstanding -> issue_stall=1.
- Reset asserted while hold full and pending=0x0000_0280 -> immediately pending=0, long_ready=1, RegWrite=0. No write of the held data after release.
